// File: rtl/dma_device_pkg.sv
// Shared types for the DMA device endpoint: FSM states and direction codes.
// Optional DMA_DEVICE_STATS_EN adds a transfer counter at the top level.
package dma_device_pkg;
  typedef enum logic [2:0] {
    IDLE,
    REQ,
    XFER,
    RECOVER,
    DONE
  } state_e;

  localparam logic DIR_DEV2MEM = 1'b0;
  localparam logic DIR_MEM2DEV = 1'b1;
endpackage

// File: rtl/dma_byte_fifo.sv
// Show-ahead byte FIFO with occupancy count.
// The head reads as 8'h00 whenever the FIFO is empty.
module dma_byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [7:0]               push_data_i,
  input  logic                     pop_i,
  output logic [7:0]               head_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     full_o,
  output logic                     empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == FULL_CNT);
  assign empty_o = (cnt_q == '0);
  assign level_o = cnt_q;
  assign head_o  = empty_o ? 8'h00 : mem[rd_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_d  = do_push ? wr_q + AW'(1) : wr_q;
    rd_d  = do_pop ? rd_q + AW'(1) : rd_q;
    cnt_d = cnt_q;
    if (do_push && !do_pop) cnt_d = cnt_q + (AW+1)'(1);
    if (do_pop && !do_push) cnt_d = cnt_q - (AW+1)'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q] <= push_data_i;
  end
endmodule

// File: rtl/dma_device_endpoint.sv
// Device-side DREQ/DACK/TC peer with a byte FIFO toward the peripheral core.
// Define DMA_DEVICE_STATS_EN to add the xfer_count output.
module dma_device_endpoint
  import dma_device_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int THRESHOLD  = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          dir,
  output logic                          dma_request,
  input  logic                          dma_acknowledge,
  input  logic                          terminal_count,
  input  logic                          dma_wr_strobe,
  input  logic [7:0]                    dma_wr_data,
  input  logic                          dma_rd_strobe,
  output logic [7:0]                    dma_rd_data,
  input  logic                          dev_push,
  input  logic [7:0]                    dev_push_data,
  input  logic                          dev_pop,
  output logic [7:0]                    dev_pop_data,
  output logic                          dev_full,
  output logic                          dev_empty,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          tc_done,
  input  logic                          tc_clear,
  output logic                          overrun
`ifdef DMA_DEVICE_STATS_EN
  ,
  output logic [15:0]                   xfer_count
`endif
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  state_e        state_q, state_d;
  logic          dir_q, dir_d;
  logic          overrun_q, overrun_d;
  logic          eff_dir, strb, qual, in_xfer, ready;
  logic          dma_push, dma_pop, dma_fail, dev_drop;
  logic          f_push, f_pop;
  logic [7:0]    f_data, head;
  logic [LW-1:0] free;

  // Outside IDLE the direction is the one latched when the request began
  assign eff_dir  = (state_q == IDLE) ? dir : dir_q;
  assign strb     = (eff_dir == DIR_MEM2DEV) ? dma_wr_strobe : dma_rd_strobe;
  assign qual     = dma_acknowledge && strb;
  assign in_xfer  = (state_q == XFER);

  assign dma_push = qual && in_xfer && (eff_dir == DIR_MEM2DEV) && !dev_full;
  assign dma_pop  = qual && in_xfer && (eff_dir == DIR_DEV2MEM) && !dev_empty;
  assign dma_fail = qual && ((eff_dir == DIR_MEM2DEV) ? dev_full : dev_empty);
  assign dev_drop = dev_push && (dev_full || dma_push);

  assign f_push = dma_push || dev_push;
  assign f_data = dma_push ? dma_wr_data : dev_push_data;
  assign f_pop  = dma_pop || dev_pop;

  dma_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (f_push),
    .push_data_i (f_data),
    .pop_i       (f_pop),
    .head_o      (head),
    .level_o     (fifo_level),
    .full_o      (dev_full),
    .empty_o     (dev_empty)
  );

  assign dma_rd_data  = head;
  assign dev_pop_data = head;

  assign free  = LW'(FIFO_DEPTH) - fifo_level;
  assign ready = (dir == DIR_MEM2DEV) ? (free >= LW'(THRESHOLD))
                                      : (fifo_level >= LW'(THRESHOLD));

  assign dma_request = (state_q == REQ) || (state_q == XFER);
  assign tc_done     = (state_q == DONE);
  assign overrun     = overrun_q;

  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    overrun_d = overrun_q || dma_fail || dev_drop;
    unique case (state_q)
      IDLE: begin
        if (enable && ready && !tc_done) begin
          state_d = REQ;
          dir_d   = dir;
        end
      end
      REQ: begin
        if (!enable) state_d = IDLE;
        else if (dma_acknowledge) state_d = XFER;
      end
      XFER: begin
        if (qual) state_d = terminal_count ? DONE : RECOVER;
        else if (!dma_acknowledge) state_d = REQ;
      end
      RECOVER: state_d = IDLE;
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
    if (tc_clear) begin
      state_d   = IDLE;
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      dir_q     <= DIR_DEV2MEM;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      overrun_q <= overrun_d;
    end
  end

`ifdef DMA_DEVICE_STATS_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (dma_push || dma_pop) cnt_d = cnt_q + 16'd1;
    if (tc_clear) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign xfer_count = cnt_q;
`endif
endmodule

// File: tb/tb_dma_device_endpoint.sv
// Directed bench for dma_device_endpoint with a 4-entry FIFO.
module tb_dma_device_endpoint;
  logic       clk = 1'b0;
  logic       reset;
  logic       enable, dir;
  logic       dma_request, dma_acknowledge, terminal_count;
  logic       dma_wr_strobe, dma_rd_strobe;
  logic [7:0] dma_wr_data, dma_rd_data;
  logic       dev_push, dev_pop;
  logic [7:0] dev_push_data, dev_pop_data;
  logic       dev_full, dev_empty;
  logic [2:0] fifo_level;
  logic       tc_done, tc_clear, overrun;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dma_device_endpoint #(.FIFO_DEPTH(4), .THRESHOLD(1)) dut (
    .clk             (clk),
    .reset           (reset),
    .enable          (enable),
    .dir             (dir),
    .dma_request     (dma_request),
    .dma_acknowledge (dma_acknowledge),
    .terminal_count  (terminal_count),
    .dma_wr_strobe   (dma_wr_strobe),
    .dma_wr_data     (dma_wr_data),
    .dma_rd_strobe   (dma_rd_strobe),
    .dma_rd_data     (dma_rd_data),
    .dev_push        (dev_push),
    .dev_push_data   (dev_push_data),
    .dev_pop         (dev_pop),
    .dev_pop_data    (dev_pop_data),
    .dev_full        (dev_full),
    .dev_empty       (dev_empty),
    .fifo_level      (fifo_level),
    .tc_done         (tc_done),
    .tc_clear        (tc_clear),
    .overrun         (overrun)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mem2dev_xfer(input logic [7:0] b, input logic tc);
    // Starts in IDLE with room in the FIFO, ends after the DREQ-low gap
    tick();
    chk("m2d_req", dma_request, 1);
    dma_acknowledge = 1;
    tick();
    chk("m2d_xfer_req", dma_request, 1);
    dma_wr_strobe = 1;
    dma_wr_data = b;
    terminal_count = tc;
    tick();
    dma_wr_strobe = 0;
    dma_acknowledge = 0;
    terminal_count = 0;
    chk("m2d_gap", dma_request, 0);
    if (!tc) begin
      tick();
      chk("m2d_idle", dma_request, 0);
    end
  endtask

  initial begin
    reset = 1; enable = 0; dir = 0;
    dma_acknowledge = 0; terminal_count = 0;
    dma_wr_strobe = 0; dma_wr_data = 8'h00; dma_rd_strobe = 0;
    dev_push = 0; dev_push_data = 8'h00; dev_pop = 0; tc_clear = 0;
    tick();
    tick();
    chk("rst_req", dma_request, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_empty", dev_empty, 1);
    chk("rst_full", dev_full, 0);
    chk("rst_tc", tc_done, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_rd", dma_rd_data, 8'h00);
    chk("rst_pop", dev_pop_data, 8'h00);
    reset = 0;
    tick();

    // dev->mem: one byte out through DACK + rd strobe
    enable = 1; dir = 0;
    dev_push = 1; dev_push_data = 8'hA5;
    tick();
    dev_push = 0;
    chk("d2m_pre_req", dma_request, 0);
    chk("d2m_level1", fifo_level, 1);
    tick();
    chk("d2m_req", dma_request, 1);
    dma_acknowledge = 1;
    tick();
    chk("d2m_rd_data", dma_rd_data, 8'hA5);
    dma_rd_strobe = 1;
    tick();
    dma_rd_strobe = 0; dma_acknowledge = 0;
    chk("d2m_req_low", dma_request, 0);
    chk("d2m_level0", fifo_level, 0);
    tick();
    chk("d2m_idle", dma_request, 0);

    // mem->dev: three single transfers, then core drains in order
    dir = 1;
    mem2dev_xfer(8'h11, 0);
    mem2dev_xfer(8'h22, 0);
    mem2dev_xfer(8'h33, 0);
    enable = 0;
    chk("m2d_level3", fifo_level, 3);
    chk("m2d_head11", dev_pop_data, 8'h11);
    dev_pop = 1;
    tick();
    chk("m2d_head22", dev_pop_data, 8'h22);
    tick();
    chk("m2d_head33", dev_pop_data, 8'h33);
    tick();
    dev_pop = 0;
    chk("m2d_empty", dev_empty, 1);

    // TC on the third strobe parks the FSM in DONE
    enable = 1;
    mem2dev_xfer(8'h44, 0);
    mem2dev_xfer(8'h55, 0);
    mem2dev_xfer(8'h66, 1);
    chk("tc_done", tc_done, 1);
    chk("tc_level", fifo_level, 3);
    tick();
    tick();
    chk("tc_hold_req", dma_request, 0);
    chk("tc_hold_done", tc_done, 1);
    tc_clear = 1;
    tick();
    tc_clear = 0;
    chk("tc_cleared", tc_done, 0);
    tick();
    chk("tc_resume_req", dma_request, 1);

    // Ack dropped in XFER without a strobe goes back to REQ
    dma_acknowledge = 1;
    tick();
    chk("ackdrop_xfer_req", dma_request, 1);
    dma_acknowledge = 0;
    tick();
    chk("ackdrop_req", dma_request, 1);
    chk("ackdrop_level", fifo_level, 3);

    // Fill to full, then a stray strobe overruns
    dma_acknowledge = 1;
    tick();
    dma_wr_strobe = 1; dma_wr_data = 8'h77;
    tick();
    dma_wr_strobe = 0; dma_acknowledge = 0;
    chk("full_level", fifo_level, 4);
    chk("full_flag", dev_full, 1);
    tick();
    tick();
    tick();
    chk("full_no_req", dma_request, 0);
    dma_acknowledge = 1; dma_wr_strobe = 1; dma_wr_data = 8'h88;
    tick();
    dma_acknowledge = 0; dma_wr_strobe = 0;
    chk("ovr_set", overrun, 1);
    chk("ovr_level", fifo_level, 4);
    chk("ovr_head", dev_pop_data, 8'h44);
    chk("ovr_no_req", dma_request, 0);
    tc_clear = 1;
    tick();
    tc_clear = 0;
    chk("ovr_clear", overrun, 0);

    // Async reset mid-XFER with three bytes queued
    dev_pop = 1;
    tick();
    dev_pop = 0;
    chk("pre_rst_level", fifo_level, 3);
    tick();
    chk("pre_rst_req", dma_request, 1);
    dma_acknowledge = 1;
    tick();
    chk("pre_rst_xfer", dma_request, 1);
    #2;
    reset = 1;
    #1;
    chk("arst_req", dma_request, 0);
    chk("arst_level", fifo_level, 0);
    chk("arst_tc", tc_done, 0);
    chk("arst_empty", dev_empty, 1);
    dma_acknowledge = 0;
    tick();
    reset = 0;
    enable = 0; dir = 0;
    tick();

    // Coincident core push and pop leave the level unchanged
    dev_push = 1; dev_push_data = 8'hAA;
    tick();
    dev_push_data = 8'hBB;
    tick();
    dev_push_data = 8'hCC; dev_pop = 1;
    tick();
    dev_push = 0; dev_pop = 0;
    chk("pp_level", fifo_level, 2);
    chk("pp_head", dev_pop_data, 8'hBB);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
